// File: rtl/piso_reg11.sv
// -----------------------------------------------------------------------------
// piso_reg11 -- parallel-in, serial-out unloader for an 11-bit word.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per accepted cycle to bit-serial arithmetic stages, LSB-first or MSB-first.
// Back-to-back words can be loaded on the last-bit transfer cycle, which gives
// 100% output duty with no bubble between words.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   din         in   [WIDTH-1:0] parallel word to serialize
//   load_valid  in   din is valid
//   load_ready  out  block can accept din this cycle
//   msb_first   in   bit order, sampled with din (0 = LSB-first, 1 = MSB-first)
//   sout        out  current serial bit
//   sout_valid  out  sout holds a valid bit
//   sout_ready  in   downstream accepts sout this cycle
//   sout_first  out  sout is bit 0 of the serial stream
//   sout_last   out  sout is the final bit of the word
//   busy        out  word in flight
// -----------------------------------------------------------------------------
module piso_reg11 #(
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             msb_first,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    // A 1-bit word still needs a 1-bit counter to keep the port widths legal.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             msb_q, msb_d;

    logic in_shift;
    logic is_first;
    logic is_last;
    logic xfer;
    logic load_fire;

    // State and datapath registers; reset discards any word in flight at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;

        in_shift  = (state_q == SHIFT);
        is_first  = in_shift && (cnt_q == '0);
        is_last   = in_shift && (cnt_q == CNT_LAST);
        xfer      = in_shift && sout_ready;

        // Ready depends only on state and sout_ready, never on load_valid,
        // so an upstream that waits for ready cannot form a combinational loop.
        load_ready = (state_q == IDLE) || (is_last && sout_ready);
        load_fire  = load_valid && load_ready;

        if (load_fire) begin
            // Covers both the IDLE load and the zero-bubble reload on the
            // last-bit transfer.
            state_d = SHIFT;
            sreg_d  = din;
            msb_d   = msb_first;
            cnt_d   = '0;
        end else if (xfer) begin
            if (is_last) begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end else begin
                // Shift toward the active output end with zero fill.
                if (msb_q) begin
                    sreg_d = sreg_q << 1;
                end else begin
                    sreg_d = sreg_q >> 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Outputs are gated by state so they fall with reset without a clock.
        sout_valid = in_shift;
        busy       = in_shift;
        sout_first = is_first;
        sout_last  = is_last;
        sout       = in_shift && (msb_q ? sreg_q[WIDTH-1] : sreg_q[0]);
    end

endmodule
